// File: rtl/glove_pkg.sv
// Shared types for the glove letter path: letter indices, top-3 candidate frames
// and the commit-sequencer states.
package glove_pkg;

  localparam int IDX_W = 5;

  typedef logic [IDX_W-1:0] letter_t;
  typedef letter_t tops_t [0:2];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/letter_fifo.sv
// Output letter FIFO (power-of-two ring). rst_n is the codebase reset: asynchronous,
// active-high. A pop in the same cycle frees room for a push when full.
module letter_fifo
  import glove_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    push,
  input  logic    pop,
  input  letter_t din,
  output letter_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  letter_t          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == CNT_W'(FIFO_DEPTH));
  assign head  = empty ? {IDX_W{1'b0}} : mem_r[rd_ptr_r];

  // Accepted push/pop qualifiers
  always_comb begin
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
  end

  // Pointer and occupancy state; clear flushes without touching storage
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Letter storage write
  always_ff @(posedge clk) begin
    if (push_ok_s & ~clear) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/letter_commit_ctrl.sv
// Sequences the top-3 dedup checker for one classified frame at a time and commits
// new letters into the output FIFO. i_rst_n is asynchronous and active-high.
module letter_commit_ctrl
  import glove_pkg::*;
#(
  parameter int DEDUP_LAT  = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_clear,
  input  logic    i_valid,
  output logic    o_ready,
  input  tops_t   i_tops,
  output logic    o_dedup_start,
  output tops_t   o_dedup_tops,
  output tops_t   o_dedup_prev_tops,
  input  logic    i_dedup_next,
  output letter_t o_letter,
  output logic    o_letter_valid,
  input  logic    i_letter_ready,
  output logic    o_overflow,
  output logic    o_busy
);

  localparam int CNT_W = (DEDUP_LAT > 1) ? $clog2(DEDUP_LAT) : 1;

  state_t           state_r;
  state_t           next_s;
  tops_t            cur_r;
  tops_t            prev_r;
  logic             prev_valid_r;
  logic             verdict_r;
  logic             overflow_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;
  logic             new_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;

  assign o_dedup_tops      = cur_r;
  assign o_dedup_prev_tops = prev_r;
  assign o_overflow        = overflow_r;
  assign o_letter_valid    = ~empty_s;

  // State register
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) state_r <= S_IDLE;
    else         state_r <= next_s;
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    next_s = state_r;
    if (i_clear) begin
      next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:   next_s = accept_s ? S_ISSUE : S_IDLE;
        S_ISSUE:  next_s = S_WAIT;
        S_WAIT:   next_s = (cnt_r == {CNT_W{1'b0}}) ? S_COMMIT : S_WAIT;
        S_COMMIT: next_s = S_IDLE;
        default:  next_s = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs and commit qualifiers
  always_comb begin
    o_ready       = (state_r == S_IDLE) & ~i_clear;
    o_busy        = (state_r != S_IDLE);
    o_dedup_start = (state_r == S_ISSUE) & ~i_clear;
    accept_s      = i_valid & o_ready;
    new_s         = verdict_r | ~prev_valid_r;
    pop_s         = ~empty_s & i_letter_ready;
    push_s        = (state_r == S_COMMIT) & new_s & ~i_clear;
    drop_s        = push_s & full_s & ~pop_s;
  end

  // Frame, verdict, wait counter and sticky overflow
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      cur_r        <= '{default: {IDX_W{1'b0}}};
      prev_r       <= '{default: {IDX_W{1'b0}}};
      prev_valid_r <= 1'b0;
      verdict_r    <= 1'b0;
      overflow_r   <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      prev_valid_r <= 1'b0;
      verdict_r    <= 1'b0;
      overflow_r   <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) cur_r <= i_tops;
        end
        S_ISSUE: begin
          cnt_r <= CNT_W'(DEDUP_LAT - 1);
        end
        S_WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) verdict_r <= i_dedup_next;
          else                        cnt_r     <= cnt_r - CNT_W'(1);
        end
        S_COMMIT: begin
          prev_r       <= cur_r;
          prev_valid_r <= 1'b1;
          if (drop_s) overflow_r <= 1'b1;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  letter_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (i_clear),
    .push  (push_s),
    .pop   (pop_s),
    .din   (cur_r[0]),
    .head  (o_letter),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: doc/letter_commit_ctrl.md
Name: letter_commit_ctrl

Overview:
Sequences the top-3 dedup checker between the gesture classifier and the text output path. It accepts one classified frame of 3 candidate letter indices and, on its own schedule, presents that frame and the previous frame to the dedup checker. It fires the checker's start strobe and samples the new-letter verdict after a fixed latency. A new letter commits tops[0] into a small output FIFO drained by the display/UART side.

Parameters:
DEDUP_LAT, 3, cycles from the o_dedup_start cycle to the cycle in which i_dedup_next is valid (min 1).
FIFO_DEPTH, 8, output letter FIFO entries (power of 2, ≥2).
IDX_W, 5, width of a letter index.

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst_n  in  1  reset, asynchronous, active-high
i_clear  in  1  sync clear: flush FIFO, drop prev frame, clear overflow, return to S_IDLE
i_valid  in  1  classifier frame valid
o_ready  out  1  frame accepted when i_valid & o_ready
i_tops  in  3xIDX_W  candidate indices, [0] = best
o_dedup_start  out  1  one-cycle start strobe to dedup checker
o_dedup_tops  out  3xIDX_W  current frame to checker
o_dedup_prev_tops  out  3xIDX_W  previous frame to checker
i_dedup_next  in  1  checker verdict: 1 = new letter
o_letter  out  IDX_W  FIFO head
o_letter_valid  out  1  FIFO non-empty
i_letter_ready  in  1  consumer pop; pop when valid & ready
o_overflow  out  1  sticky: a letter was dropped because the FIFO was full
o_busy  out  1  FSM not in S_IDLE

Behaviour:
- Reset: state S_IDLE; cur/prev regs 0; prev_valid 0; FIFO empty; wait counter 0.
- Reset output values: o_ready 1, o_dedup_start 0, o_dedup_tops 0, o_dedup_prev_tops 0, o_letter 0, o_letter_valid 0, o_overflow 0, o_busy 0.
- o_ready = (state == S_IDLE) & ~i_clear.
- o_dedup_tops/o_dedup_prev_tops are driven from the cur/prev regs. They are stable from S_ISSUE through the end of S_WAIT.
- FSM:
  - S_IDLE: on i_valid & o_ready, latch i_tops into cur, then go to S_ISSUE.
  - S_ISSUE: o_dedup_start = 1 for exactly this cycle (cycle T). Load wait counter to DEDUP_LAT-1, then go to S_WAIT.
  - S_WAIT: decrement the counter each cycle. In the cycle T+DEDUP_LAT (counter == 0), sample i_dedup_next into verdict, then go to S_COMMIT.
  - S_COMMIT: compute new = verdict | ~prev_valid. The first frame after reset/clear always commits. If new and the FIFO is not full, push cur[0]. If new and the FIFO is full, drop the letter and set o_overflow. Always set prev <= cur and prev_valid <= 1, then go to S_IDLE.
- Frame throughput: one frame per DEDUP_LAT+3 cycles; i_valid is ignored while busy (no queuing upstream).
- i_dedup_next is ignored outside the sample cycle.
- FIFO:
  - Push and pop in the same cycle: legal when non-empty; count is unchanged.
  - Push and pop in the same cycle when full: pop frees a slot, so the push succeeds and there is no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
- i_clear has priority over all events in the same cycle, including an S_COMMIT push and an accept. It does not pulse o_dedup_start.
- Async reset mid-sequence aborts immediately; no strobe or push occurs afterwards.
- Indices are passed unchanged; no range check.

Decomposition:
- Package glove_pkg:
  - IDX_W
  - typedef logic [IDX_W-1:0] letter_t
  - typedef letter_t tops_t [0:2]
  - state enum {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT}
- Sub-module letter_fifo: synchronous FIFO with push/pop/full/empty/head, parameterised by FIFO_DEPTH.

Test Plan:
- First frame after reset, tops {3,7,9}, i_dedup_next held 0 → start strobe in cycle T, letter 3 enqueued, o_letter_valid=1 at T+DEDUP_LAT+2.
- Second frame {3,7,12}, dedup returns 0 at T+3 → no push, o_dedup_prev_tops={3,7,9}, prev becomes {3,7,12}.
- Frame {20,1,2}, dedup returns 1 → 20 enqueued behind 3. With i_letter_ready=1, pops deliver 3 then 20 in order.
- With i_letter_ready=0, issue 9 new frames with DEPTH 8 → 8 letters stored, 9th dropped, o_overflow=1 and sticky. Then push and pop in the same cycle when full → no overflow and count stays 8.
- i_valid held during S_WAIT with different tops → ignored; o_ready=0; o_dedup_tops unchanged; only one strobe.
- i_clear asserted in S_COMMIT with verdict 1 → no push, FIFO empty, prev_valid=0. The next frame commits regardless of verdict.
- Async reset asserted in S_WAIT → all outputs at reset values immediately; no strobe afterwards until a new accept.
